// File: rtl/mem_resp_demux_pkg.sv
// mem_demux_pkg: shared types for the memory response demultiplexer.
//   NUM_CLI    number of client ports served by the demux
//   cli_idx_t  client index (2 bits)
//   state_t    transaction FSM states IDLE / BUSY / RESP
//   op_t       latched operation READ / WRITE
//   cli_next() round-robin successor of a client index (wraps 3 -> 0)
package mem_demux_pkg;

  localparam int NUM_CLI = 4;

  typedef logic [1:0] cli_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  // Successor index; the 2-bit width gives the modulo-4 wrap for free.
  function automatic cli_idx_t cli_next(input cli_idx_t idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_resp_demux_if.sv
// mem_resp_demux_if: bundles the four client request/response lanes and the
// single memory-side request/response port.
//   cli_read/cli_write/cli_addr/cli_wdata : client requests (held until cli_resp)
//   cli_resp/cli_rdata                    : one-hot completion and read data
//   mem_read/mem_write/mem_addr/mem_wdata : request to memory
//   mem_resp/mem_rdata                    : memory completion and read data
// Modports: master = clients + memory environment, slave = the demux.
interface mem_resp_demux_if
  import mem_demux_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
);

  logic [NUM_CLI-1:0]             cli_read;
  logic [NUM_CLI-1:0]             cli_write;
  logic [NUM_CLI-1:0][ADDR_W-1:0] cli_addr;
  logic [NUM_CLI-1:0][DATA_W-1:0] cli_wdata;
  logic [NUM_CLI-1:0]             cli_resp;
  logic [NUM_CLI-1:0][DATA_W-1:0] cli_rdata;
  logic                           mem_read;
  logic                           mem_write;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_resp;
  logic [DATA_W-1:0]              mem_rdata;

  modport master (
    output cli_read, cli_write, cli_addr, cli_wdata, mem_resp, mem_rdata,
    input  cli_resp, cli_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  cli_read, cli_write, cli_addr, cli_wdata, mem_resp, mem_rdata,
    output cli_resp, cli_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_resp_demux_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i   : per-client request bits
//   ptr_i   : client with highest priority this round
//   valid_o : at least one request present
//   idx_o   : first requesting client found from ptr_i upward, wrapping 3 -> 0
module rr_picker
  import mem_demux_pkg::*;
(
  input  logic [NUM_CLI-1:0] req_i,
  input  cli_idx_t           ptr_i,
  output logic               valid_o,
  output cli_idx_t           idx_o
);

  cli_idx_t cand_s;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand_s  = ptr_i;
    for (int k = NUM_CLI - 1; k >= 0; k--) begin
      cand_s  = ptr_i + cli_idx_t'(k);
      valid_o = valid_o | req_i[cand_s];
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/mem_resp_demux.sv
// mem_resp_demux: arbitrates four clients onto one memory port and routes the
// memory completion back to the client that issued the request.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_resp_demux_if.slave (client lanes + memory port)
// One transaction at a time: IDLE grants, BUSY waits for mem_resp, RESP pulses
// cli_resp to the owner for one cycle and advances the round-robin pointer.
module mem_resp_demux
  import mem_demux_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_resp_demux_if.slave     bus
);

  state_t              state_q, state_d;
  cli_idx_t            owner_q, owner_d;
  cli_idx_t            rr_ptr_q, rr_ptr_d;
  op_t                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_CLI-1:0]  req_s;
  logic                pick_valid_s;
  cli_idx_t            pick_idx_s;

  assign req_s = bus.cli_read | bus.cli_write;

  rr_picker u_rr_picker (
    .req_i   (req_s),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Next-state and latch logic of the transaction FSM.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = BUSY;
          owner_d = pick_idx_s;
          // Read wins when a client raises both read and write.
          op_d    = bus.cli_read[pick_idx_s] ? READ : WRITE;
          addr_d  = bus.cli_addr[pick_idx_s];
          wdata_d = bus.cli_wdata[pick_idx_s];
          // Cleared so a write never returns stale read data.
          rdata_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          state_d = RESP;
          rdata_d = (op_q == READ) ? bus.mem_rdata : '0;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d  = IDLE;
        rr_ptr_d = cli_next(owner_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      op_q     <= READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded purely from registers: no input reaches an output combinationally.
  always_comb begin
    bus.cli_resp            = '0;
    bus.cli_rdata           = '0;
    bus.cli_resp[owner_q]   = (state_q == RESP);
    bus.cli_rdata[owner_q]  = (state_q == RESP) ? rdata_q : '0;
    bus.mem_read            = (state_q == BUSY) && (op_q == READ);
    bus.mem_write           = (state_q == BUSY) && (op_q == WRITE);
    bus.mem_addr            = addr_q;
    bus.mem_wdata           = wdata_q;
  end

endmodule

// File: tb/tb_mem_resp_demux.sv
module tb_mem_resp_demux;

  localparam int DW = 128;
  localparam int AW = 16;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_resp_demux_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_resp_demux #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: one outstanding memory transaction and one
  // completion being reported, plus the next client to favour.
  bit              m_txn;
  bit              m_txn_rd;
  int              m_txn_own;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  bit              m_resp;
  int              m_resp_own;
  logic [DW-1:0]   m_resp_data;
  int              m_ptr;

  bit              auto_mem, spur_en, rand_cli, fix_rdata;
  logic [DW-1:0]   fix_val;
  int              mem_lat, busy_cnt, cyc;
  bit [NC-1:0]     pend;

  task automatic chk(input string name, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_txn   = 1'b0;
    m_resp  = 1'b0;
    m_ptr   = 0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  task automatic model_update();
    logic [NC-1:0] req;
    bit found;
    int c;
    req = bus.cli_read | bus.cli_write;
    found = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else if (m_resp) begin
      m_resp = 1'b0;
      m_ptr  = (m_resp_own + 1) % NC;
    end else if (m_txn) begin
      if (bus.mem_resp) begin
        m_resp      = 1'b1;
        m_resp_own  = m_txn_own;
        m_resp_data = m_txn_rd ? bus.mem_rdata : '0;
        m_txn       = 1'b0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        c = (m_ptr + k) % NC;
        if (!found && req[c]) begin
          found     = 1'b1;
          m_txn     = 1'b1;
          m_txn_own = c;
          m_txn_rd  = bus.cli_read[c];
          m_addr    = bus.cli_addr[c];
          m_wdata   = bus.cli_wdata[c];
        end
      end
    end
  endtask

  task automatic compare();
    logic [NC-1:0]    e_resp;
    logic [NC*DW-1:0] e_rdata;
    e_resp  = '0;
    e_rdata = '0;
    if (m_resp) begin
      e_resp[m_resp_own] = 1'b1;
      e_rdata[m_resp_own*DW +: DW] = m_resp_data;
    end
    chk("cli_resp",  bus.cli_resp,  e_resp);
    chk("cli_rdata", bus.cli_rdata, e_rdata);
    chk("mem_read",  bus.mem_read,  m_txn && m_txn_rd);
    chk("mem_write", bus.mem_write, m_txn && !m_txn_rd);
    chk("mem_addr",  bus.mem_addr,  m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
  endtask

  task automatic drive_mem();
    if (bus.mem_read || bus.mem_write) begin
      busy_cnt++;
      bus.mem_resp = auto_mem && (busy_cnt > mem_lat);
    end else begin
      busy_cnt = 0;
      if (rand_cli) mem_lat = $urandom_range(0, 4);
      bus.mem_resp = spur_en && ($urandom_range(0, 7) == 0);
    end
    bus.mem_rdata = fix_rdata ? fix_val : {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_cli();
    int op;
    for (int i = 0; i < NC; i++) begin
      if (m_resp && m_resp_own == i) begin
        pend[i] = 1'b0;
        bus.cli_read[i]  = 1'b0;
        bus.cli_write[i] = 1'b0;
      end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 2);
        pend[i] = 1'b1;
        bus.cli_read[i]  = (op != 1);
        bus.cli_write[i] = (op != 0);
        bus.cli_addr[i]  = AW'($urandom);
        bus.cli_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    compare();
    drive_mem();
    if (rand_cli) drive_cli();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare();
    step();
    reset_n = 1'b1;
  endtask

  int n_rd, got, npulse, busy_seen;
  bit seen_w;
  logic [NC-1:0] pulses [4];
  int pcyc [4];

  initial begin
    bus.cli_read = '0; bus.cli_write = '0; bus.cli_addr = '0; bus.cli_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    auto_mem = 1'b0; spur_en = 1'b0; rand_cli = 1'b0; fix_rdata = 1'b0; fix_val = '0;
    mem_lat = 0; busy_cnt = 0; cyc = 0; pend = '0;
    model_reset();

    // Reset state
    repeat (2) step();
    chk("rst_cli_resp", bus.cli_resp, 4'b0000);
    chk("rst_cli_rdata", bus.cli_rdata, '0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    reset_n = 1'b1;
    step();

    // Single read, memory answers in the 4th busy cycle
    auto_mem = 1'b1; mem_lat = 3; fix_rdata = 1'b1; fix_val = {16{8'hA5}};
    bus.cli_addr[0] = 16'h1230; bus.cli_read = 4'b0001;
    n_rd = 0; got = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.mem_read) begin
        n_rd++;
        if (n_rd == 1) chk("t1_mem_addr", bus.mem_addr, 16'h1230);
      end
      if (bus.cli_resp != 4'b0000) begin
        got++;
        chk("t1_cli_resp", bus.cli_resp, 4'b0001);
        chk("t1_rdata0", bus.cli_rdata[0], {16{8'hA5}});
        bus.cli_read = 4'b0000;
      end
    end
    chk("t1_mem_read_cycles", n_rd, 4);
    chk("t1_resp_count", got, 1);

    // Contention: all four clients, 1-cycle memory
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < NC; i++) bus.cli_addr[i] = 16'(16'h0100 * i);
    bus.cli_read = 4'b1111;
    npulse = 0;
    for (int k = 0; k < 40 && npulse < 4; k++) begin
      step();
      if (bus.cli_resp != 4'b0000) begin
        pulses[npulse] = bus.cli_resp;
        pcyc[npulse]   = cyc;
        npulse++;
        bus.cli_read = bus.cli_read & ~bus.cli_resp;
      end
    end
    chk("t2_pulse_count", npulse, 4);
    for (int i = 0; i < npulse; i++) begin
      chk($sformatf("t2_pulse%0d", i), pulses[i], 4'b0001 << i);
      if (i > 0) chk($sformatf("t2_spacing%0d", i), pcyc[i] - pcyc[i-1], 4);
    end

    // Write on client 2; memory read data must not leak to the client
    bus.cli_addr[2] = 16'h00F0; bus.cli_wdata[2] = {16{8'h55}}; bus.cli_write = 4'b0100;
    mem_lat = 2; seen_w = 1'b0; got = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.mem_write && !seen_w) begin
        seen_w = 1'b1;
        chk("t3_mem_wdata", bus.mem_wdata, {16{8'h55}});
        chk("t3_mem_addr", bus.mem_addr, 16'h00F0);
        chk("t3_mem_read", bus.mem_read, 1'b0);
      end
      if (bus.cli_resp != 4'b0000) begin
        got++;
        chk("t3_cli_resp", bus.cli_resp, 4'b0100);
        chk("t3_cli_rdata", bus.cli_rdata, '0);
        bus.cli_write = 4'b0000;
      end
    end
    chk("t3_write_seen", seen_w, 1'b1);
    chk("t3_resp_count", got, 1);

    // Reset mid-BUSY: serve client 0 first so the pointer sits at 1
    mem_lat = 0; bus.cli_read = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.cli_resp != 4'b0000) bus.cli_read = 4'b0000;
    end
    auto_mem = 1'b0; bus.cli_read = 4'b0010; n_rd = 0;
    for (int k = 0; k < 4 && n_rd == 0; k++) begin
      step();
      if (bus.mem_read) n_rd++;
    end
    chk("t4_client1_busy", n_rd, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare();
    chk("t4_rst_outputs", {bus.cli_resp, bus.mem_read, bus.mem_write, bus.mem_addr}, 22'h0);
    bus.cli_read = 4'b0000;
    step();
    reset_n = 1'b1;
    bus.mem_resp = 1'b1;
    step();
    bus.mem_resp = 1'b0;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.cli_resp != 4'b0000) got++;
    end
    chk("t4_no_resp_after_reset", got, 0);
    auto_mem = 1'b1; bus.cli_read = 4'b1001; got = 0;
    for (int k = 0; k < 12 && got == 0; k++) begin
      step();
      if (bus.cli_resp != 4'b0000) begin
        got++;
        chk("t4_ptr_reset_grant", bus.cli_resp, 4'b0001);
        bus.cli_read = 4'b0000;
      end
    end
    chk("t4_resp_count", got, 1);
    bus.cli_read = 4'b0000;
    repeat (3) step();

    // Spurious mem_resp in IDLE
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.mem_resp = 1'b1;
      step();
      chk("t5_idle_outputs", {bus.cli_resp, bus.mem_read, bus.mem_write, bus.mem_addr}, 22'h0);
      chk("t5_idle_rdata", bus.cli_rdata, '0);
    end
    bus.mem_resp = 1'b0;

    // Read+write on client 3 is a read
    bus.cli_addr[3] = 16'hBEEF; bus.cli_read = 4'b1000; bus.cli_write = 4'b1000;
    mem_lat = 2; busy_seen = 0; got = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.mem_read || bus.mem_write) begin
        busy_seen++;
        chk("t6_rw", {bus.mem_read, bus.mem_write}, 2'b10);
      end
      if (bus.cli_resp != 4'b0000) begin
        got++;
        chk("t6_cli_resp", bus.cli_resp, 4'b1000);
        bus.cli_read = 4'b0000; bus.cli_write = 4'b0000;
      end
    end
    chk("t6_busy_cycles", busy_seen, 3);
    chk("t6_resp_count", got, 1);

    // Randomized traffic against the reference model
    fix_rdata = 1'b0; spur_en = 1'b1; rand_cli = 1'b1; pend = '0;
    bus.cli_read = 4'b0000; bus.cli_write = 4'b0000;
    for (int k = 0; k < 3000; k++) begin
      step();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
